// File: rtl/pc_flag_unit.sv
// Program counter, N/V/Z flag register, branch resolution and sticky halt.
// Branches resolve against the registered flags only. A flag write becomes visible to the next instruction.
module pc_flag_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  flag_in,
  input  logic        flag_we,
  output logic [2:0]  flag_q,
  input  logic        br_imm,
  input  logic        br_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] rs_data,
  input  logic        halt,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic        halted
);

  logic        flag_n, flag_v, flag_z;
  logic        cond_true;
  logic [15:0] br_off;
  logic [15:0] target;

  assign flag_n = flag_q[0];
  assign flag_v = flag_q[1];
  assign flag_z = flag_q[2];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z | ~flag_n;
      3'b101: cond_true = flag_n | flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_plus2 = pc + 16'd2;
  // Word offset: sign-extend imm9 and shift left by one in a single concatenation.
  assign br_off   = {{6{imm9[8]}}, imm9, 1'b0};
  assign target   = br_reg ? {rs_data[15:1], 1'b0} : (pc_plus2 + br_off);
  assign taken    = (br_imm | br_reg) & cond_true & ~halted & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      flag_q <= 3'b000;
      halted <= 1'b0;
    end else if (!halted && !stall) begin
      if (halt)       halted <= 1'b1;
      else if (taken) pc     <= target;
      else            pc     <= pc_plus2;
      if (flag_we)    flag_q <= flag_in;
    end
  end

endmodule

// File: doc/pc_flag_unit.md
# pc_flag_unit

Sequential program-flow and flag-state block for the single-cycle processor. It holds the architectural N/V/Z flag register written from the ALU's FLAG output and drives the registered flags back to the ALU's FLAG_in. It owns the PC register and resolves conditional branches against the registered flags. It also implements sticky halt and pipeline-style stall holding.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flag_in  in  3  flags from ALU; bit0 = N, bit1 = V, bit2 = Z.
- flag_we  in  1  current instruction writes flags.
- flag_q  out  3  registered flags, same bit order; feeds ALU FLAG_in.
- br_imm  in  1  current instruction is PC-relative branch (B).
- br_reg  in  1  current instruction is register branch (BR).
- cond  in  3  branch condition code.
- imm9  in  9  signed word offset for B.
- rs_data  in  16  register target for BR.
- halt  in  1  current instruction is HLT.
- stall  in  1  hold the current instruction; no state commits.
- pc  out  16  current PC, registered.
- pc_plus2  out  16  pc + 2, combinational.
- taken  out  1  branch taken this cycle, combinational.
- halted  out  1  processor halted, registered, sticky.

## Operation
- Condition decode on flag_q (Z = flag_q[2], N = flag_q[0], V = flag_q[1]):
  - 000 NEQ: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: N=1 or Z=1.
  - 110 OVFL: V=1.
  - 111 UNCOND: always.
- Branch conditions always use registered flag_q, never flag_in, including when flag_we is high in the same cycle.
- taken = (br_imm | br_reg) & cond_true & ~halted & ~rst_n_asserted.
- Branch targets:
  - B: target = pc_plus2 + (sext16(imm9) << 1), modulo 2^16.
  - BR: target = {rs_data[15:1], 1'b0}.
  - If br_reg and br_imm are both high, br_reg wins.
- Next-PC priority, evaluated at each rising edge:
  1. halted: hold.
  2. stall: hold.
  3. halt: hold PC, set halted.
  4. taken: load target.
  5. Otherwise: pc_plus2.
- Flag update: flag_q <= flag_in when flag_we & ~stall & ~halted; otherwise hold.
- halted clears only on reset.
- Arithmetic is 16-bit unsigned wrap: pc 16'hFFFE + 2 = 16'h0000. Branch targets wrap identically.

## Timing
- Reset (async, rst_n low): pc = RESET_PC, flag_q = 3'b000, halted = 0, taken = 0, pc_plus2 = RESET_PC + 2. All take effect immediately, independent of clk.
- Reset deassertion is synchronous to the next rising edge. The first PC update occurs on the first rising edge with rst_n high.
- Reset mid-operation: pc, flag_q, and halted are forced to reset values within the same cycle. Any pending branch or halt is discarded.
- Latency:
  - taken and target are combinational from inputs and flag_q.
  - pc, flag_q, and halted update one edge later.
  - Flags written by instruction k are visible to a branch at instruction k+1.
- Simultaneous halt and taken branch: halt wins; PC holds at the HLT address.
- Simultaneous stall with flag_we, halt, or branch: no state changes that cycle. The same inputs re-present on the following cycle.
- Once halted: pc, flag_q, and halted are frozen, and taken = 0, regardless of inputs.

## Test plan
- Reset/increment: rst_n low, then high with RESET_PC = 0 and no control inputs → pc reads 0, 2, 4, 6 on successive edges; flag_q = 000; halted = 0.
- Flag write then branch: cycle 1, flag_in = 100 (Z) with flag_we = 1. Cycle 2, br_imm = 1, cond = 001, imm9 = 9'h1FE (−2) at pc = 16'h0010 → taken = 1; next pc = 16'h0012 − 4 = 16'h000E; flag_q = 100.
- Same-cycle flag write: flag_q = 000, flag_in = 100, flag_we = 1, br_imm = 1, cond = 001 → taken = 0 (old flags used); pc increments; flag_q becomes 100.
- Condition sweep: for each flag_q of 000, 001, 010, 100 and cond 000..111, check taken against the decode list. Examples: flag_q = 001 with cond 011 → taken = 1; flag_q = 010 with cond 110 → taken = 1.
- BR and wrap: br_reg = 1, cond = 111, rs_data = 16'h1235 → next pc = 16'h1234. Separately, pc = 16'hFFFE with no branch → next pc = 16'h0000.
- Stall/halt/reset: stall = 1 with br_imm and cond = 111 → pc and flag_q hold. Next cycle, halt = 1 and br_imm = 1 → pc holds and halted = 1. Then 3 cycles of arbitrary input → nothing changes. Async rst_n pulse mid-cycle → pc = RESET_PC and halted = 0 immediately.
